// File: rtl/microondas_pkg.sv
// ---------------------------------------------------------------------------
// microondas_pkg
//
// Shared definitions for the microwave front-end controller.
//   - Keypad codes that carry a command (digits are 0x0..0x9, the rest of
//     the code space above CLEAR is consumed without effect).
//   - The loader state encoding. ST_QLOAD is only reachable when the
//     quick-start feature is compiled into timer_loader.
//   - The digits that quick start loads into the timer (0:30).
// ---------------------------------------------------------------------------
package microondas_pkg;

    localparam logic [3:0] KEY_START = 4'hA;
    localparam logic [3:0] KEY_STOP  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    // Highest digit code and highest legal seconds-tens digit.
    localparam logic [3:0] MAX_DIGIT    = 4'd9;
    localparam logic [3:0] MAX_SEC_TENS = 4'd5;

    // Quick start loads minutes, seconds-tens, seconds-units in this order.
    localparam logic [3:0] QS_DIGIT_MIN   = 4'd0;
    localparam logic [3:0] QS_DIGIT_TENS  = 4'd3;
    localparam logic [3:0] QS_DIGIT_UNITS = 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_RUN,
        ST_PAUSE,
        ST_DONE,
        ST_QLOAD
    } loader_state_t;

    // A key code is a digit when it falls in 0..9.
    function automatic logic is_digit(input logic [3:0] code);
        return code <= MAX_DIGIT;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//
// Divides clk down to a one-cycle tick every TICK_DIV counted cycles.
// The counter only advances while run is high, so dropping run freezes it
// at its current value and raising run again continues from there.
//
// Ports
//   clk        : clock, rising edge
//   clr        : asynchronous active-high reset
//   run        : advance the counter this cycle
//   sync_reset : restart the count from zero (wins over run)
//   tick       : registered one-cycle pulse when the count wraps
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    input  logic sync_reset,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // The count starts at zero on entry and takes TICK_DIV running edges to
    // wrap, so the first tick appears TICK_DIV cycles after a sync_reset.
    // The tick is registered here so the parent can drive it straight out.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (sync_reset) begin
                count <= '0;
            end else if (run) begin
                if (count == LAST_COUNT) begin
                    count <= '0;
                    tick  <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/timer_loader.sv
// ---------------------------------------------------------------------------
// timer_loader
//
// Keypad-side controller for the microwave BCD countdown timer. Takes key
// events over a valid/ready handshake, shifts digits into the timer through
// its data/loadn port, keeps a shadow of the three loaded digits, produces
// the count-down tick, and sequences start / pause / cancel / door interlock
// and completion.
//
// Optional feature: define TIMER_LOADER_QUICK_START_EN to make START in IDLE
// load 0:30 through the QLOAD state and start cooking. Without it, START in
// IDLE is consumed and ignored.
//
// Ports
//   clk         : clock, rising edge
//   clr         : asynchronous active-high reset
//   key_valid   : key event present
//   key_code    : 0..9 digit, A start, B stop, C clear, D..F ignored
//   key_ready   : a key is accepted this cycle when key_valid is also high
//   door_open   : door interlock level
//   timer_zero  : zero flag from the countdown timer
//   data        : digit presented on the timer load port
//   loadn       : active-low one-cycle load strobe
//   timer_clrn  : active-low one-cycle clear strobe
//   en          : one-cycle count-down tick
//   running     : high while cooking
//   done        : high once the countdown finished, until a key is pressed
//   error       : invalid time rejected; cleared by the next accepted key
//   digit_count : digits entered, saturating at 3
// ---------------------------------------------------------------------------
module timer_loader
    import microondas_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic       door_open,
    input  logic       timer_zero,
    output logic [3:0] data,
    output logic       loadn,
    output logic       timer_clrn,
    output logic       en,
    output logic       running,
    output logic       done,
    output logic       error,
    output logic [1:0] digit_count
);

    loader_state_t state;

    logic [3:0] shadow_min;
    logic [3:0] shadow_tens;
    logic [3:0] shadow_units;
    logic       door_q;

    logic key_fire;
    logic key_is_digit;
    logic door_rise;
    logic start_bad;
    logic start_blank;
    logic stay_run;
    logic pre_sync_reset;

`ifdef TIMER_LOADER_QUICK_START_EN
    // Which quick-start digit goes out next while in QLOAD.
    logic [1:0] qload_idx;
`endif

    // Decode of the current cycle's events. stay_run is what keeps the
    // prescaler advancing: it drops in the very cycle we decide to leave RUN,
    // so neither a pause nor completion can let one more tick slip out, and
    // a pause leaves the count frozen where it was.
    always_comb begin
        key_fire     = key_valid && key_ready;
        key_is_digit = is_digit(key_code);
        door_rise    = door_open && !door_q;
        start_bad    = shadow_tens > MAX_SEC_TENS;
        start_blank  = (shadow_min == 4'd0) && (shadow_tens == 4'd0) &&
                       (shadow_units == 4'd0);
        stay_run     = (state == ST_RUN) && !timer_zero && !door_rise &&
                       !(key_fire && (key_code == KEY_STOP));

        pre_sync_reset = (state == ST_ENTRY) && key_fire &&
                         (key_code == KEY_START) && !start_bad && !start_blank;
`ifdef TIMER_LOADER_QUICK_START_EN
        if ((state == ST_QLOAD) && (qload_idx == 2'd2)) begin
            pre_sync_reset = 1'b1;
        end
`endif
    end

    tick_prescaler #(
        .TICK_DIV   (TICK_DIV)
    ) u_prescaler (
        .clk        (clk),
        .clr        (clr),
        .run        (stay_run),
        .sync_reset (pre_sync_reset),
        .tick       (en)
    );

    // Main controller. Every output is a register. The strobes and key_ready
    // default back to their idle levels each cycle, so any strobe is exactly
    // one cycle wide and key_ready is low only while a strobe is on the wire
    // (and throughout QLOAD). Any accepted key clears a pending error; a
    // rejected START sets it again later in the same cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= ST_IDLE;
            shadow_min   <= 4'd0;
            shadow_tens  <= 4'd0;
            shadow_units <= 4'd0;
            door_q       <= 1'b0;
            data         <= 4'd0;
            loadn        <= 1'b1;
            timer_clrn   <= 1'b1;
            key_ready    <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            digit_count  <= 2'd0;
`ifdef TIMER_LOADER_QUICK_START_EN
            qload_idx    <= 2'd0;
`endif
        end else begin
            door_q     <= door_open;
            loadn      <= 1'b1;
            timer_clrn <= 1'b1;
            key_ready  <= 1'b1;

            if (key_fire) begin
                error <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_ENTRY: begin
                    if (key_fire) begin
                        if (key_is_digit) begin
                            data         <= key_code;
                            loadn        <= 1'b0;
                            key_ready    <= 1'b0;
                            shadow_min   <= shadow_tens;
                            shadow_tens  <= shadow_units;
                            shadow_units <= key_code;
                            digit_count  <= (digit_count == 2'd3) ? 2'd3 : digit_count + 2'd1;
                            state        <= ST_ENTRY;
                        end else if ((key_code == KEY_CLEAR) ||
                                     ((key_code == KEY_STOP) && (state == ST_ENTRY))) begin
                            timer_clrn   <= 1'b0;
                            key_ready    <= 1'b0;
                            shadow_min   <= 4'd0;
                            shadow_tens  <= 4'd0;
                            shadow_units <= 4'd0;
                            digit_count  <= 2'd0;
                            state        <= ST_IDLE;
                        end else if (key_code == KEY_START) begin
                            if (state == ST_ENTRY) begin
                                if (start_bad) begin
                                    error <= 1'b1;
                                end else if (!start_blank) begin
                                    running <= 1'b1;
                                    state   <= ST_RUN;
                                end
                            end
`ifdef TIMER_LOADER_QUICK_START_EN
                            else begin
                                data         <= QS_DIGIT_MIN;
                                loadn        <= 1'b0;
                                key_ready    <= 1'b0;
                                shadow_min   <= shadow_tens;
                                shadow_tens  <= shadow_units;
                                shadow_units <= QS_DIGIT_MIN;
                                digit_count  <= (digit_count == 2'd3) ? 2'd3 : digit_count + 2'd1;
                                qload_idx    <= 2'd1;
                                state        <= ST_QLOAD;
                            end
`endif
                        end
                    end
                end

                ST_RUN: begin
                    if (timer_zero) begin
                        running <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else if (door_rise || (key_fire && (key_code == KEY_STOP))) begin
                        running <= 1'b0;
                        state   <= ST_PAUSE;
                    end
                end

                ST_PAUSE: begin
                    if (key_fire) begin
                        if (key_code == KEY_START) begin
                            if (!door_open) begin
                                running <= 1'b1;
                                state   <= ST_RUN;
                            end
                        end else if ((key_code == KEY_STOP) || (key_code == KEY_CLEAR)) begin
                            timer_clrn   <= 1'b0;
                            key_ready    <= 1'b0;
                            shadow_min   <= 4'd0;
                            shadow_tens  <= 4'd0;
                            shadow_units <= 4'd0;
                            digit_count  <= 2'd0;
                            state        <= ST_IDLE;
                        end
                    end
                end

                ST_DONE: begin
                    if (key_fire) begin
                        timer_clrn   <= 1'b0;
                        key_ready    <= 1'b0;
                        done         <= 1'b0;
                        shadow_min   <= 4'd0;
                        shadow_tens  <= 4'd0;
                        shadow_units <= 4'd0;
                        digit_count  <= 2'd0;
                        state        <= ST_IDLE;
                    end
                end

`ifdef TIMER_LOADER_QUICK_START_EN
                // The remaining two quick-start digits go out on back-to-back
                // cycles; the last one coincides with entering RUN, and
                // key_ready stays low until that strobe has finished.
                ST_QLOAD: begin
                    key_ready    <= 1'b0;
                    loadn        <= 1'b0;
                    shadow_min   <= shadow_tens;
                    shadow_tens  <= shadow_units;
                    digit_count  <= (digit_count == 2'd3) ? 2'd3 : digit_count + 2'd1;
                    if (qload_idx == 2'd1) begin
                        data         <= QS_DIGIT_TENS;
                        shadow_units <= QS_DIGIT_TENS;
                        qload_idx    <= 2'd2;
                    end else begin
                        data         <= QS_DIGIT_UNITS;
                        shadow_units <= QS_DIGIT_UNITS;
                        qload_idx    <= 2'd0;
                        running      <= 1'b1;
                        state        <= ST_RUN;
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_loader.sv
// ---------------------------------------------------------------------------
// tb_timer_loader
//
// Directed bench for timer_loader with TICK_DIV = 4. A small BCD countdown
// timer model answers loadn / timer_clrn / en and produces timer_zero.
// Expected load digits are queued when a key is driven and compared when
// the DUT drives loadn low.
// ---------------------------------------------------------------------------
module tb_timer_loader;
    import microondas_pkg::*;

    localparam int TICK_DIV = 4;
    // key_ready, loadn, timer_clrn, en, running, done, error, data, digit_count
    localparam logic [12:0] RESET_VECTOR = 13'b1_1_1_0_0_0_0_0000_00;

    logic       clk = 1'b0;
    logic       clr;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       door_open;
    logic       timer_zero;
    logic [3:0] data;
    logic       loadn;
    logic       timer_clrn;
    logic       en;
    logic       running;
    logic       done;
    logic       error;
    logic [1:0] digit_count;

    int assertions_evaluated = 0;
    int failures = 0;

    logic [3:0] expected_loads[$];

    logic [3:0] tm_min = 4'd0;
    logic [3:0] tm_tens = 4'd0;
    logic [3:0] tm_units = 4'd0;

    always #5 clk = ~clk;

    timer_loader #(
        .TICK_DIV    (TICK_DIV)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .door_open   (door_open),
        .timer_zero  (timer_zero),
        .data        (data),
        .loadn       (loadn),
        .timer_clrn  (timer_clrn),
        .en          (en),
        .running     (running),
        .done        (done),
        .error       (error),
        .digit_count (digit_count)
    );

    // Behavioural BCD countdown timer: clear, shift-load, or count down.
    always @(posedge clk) begin
        if (timer_clrn === 1'b0) begin
            tm_min   <= 4'd0;
            tm_tens  <= 4'd0;
            tm_units <= 4'd0;
        end else if (loadn === 1'b0) begin
            tm_min   <= tm_tens;
            tm_tens  <= tm_units;
            tm_units <= data;
        end else if (en === 1'b1 && !timer_zero) begin
            if (tm_units != 4'd0) begin
                tm_units <= tm_units - 4'd1;
            end else begin
                tm_units <= 4'd9;
                if (tm_tens != 4'd0) begin
                    tm_tens <= tm_tens - 4'd1;
                end else begin
                    tm_tens <= 4'd5;
                    tm_min  <= tm_min - 4'd1;
                end
            end
        end
    end

    assign timer_zero = (tm_min == 4'd0) && (tm_tens == 4'd0) && (tm_units == 4'd0);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions_evaluated++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic reportEvent(input string tag, input string observed, input string expected);
        assertions_evaluated++;
        failures++;
        $error("[TB] FAIL %s: observed %s, expected %s", tag, observed, expected);
    endtask

    task automatic checkReset(input string tag);
        checkOutput(tag, 32'({key_ready, loadn, timer_clrn, en, running, done,
                              error, data, digit_count}), 32'(RESET_VECTOR));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Present a key and hold it until the DUT accepts it; return just after
    // the accepting edge, so the response strobe is already visible.
    task automatic applyStimulus(input logic [3:0] code);
        int waited;
        waited = 0;
        key_code  = code;
        key_valid = 1'b1;
        @(negedge clk);
        while (key_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (key_ready !== 1'b1) begin
            reportEvent("key_accept", "key_ready stuck low", "key accepted");
        end
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'hF;
    endtask

    task automatic countEn(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            nextCycle();
            if (en === 1'b1) pulses++;
        end
    endtask

    // Each loadn strobe must carry the next queued digit.
    always @(negedge clk) begin : load_monitor
        logic [3:0] want;
        if (clr === 1'b0 && loadn === 1'b0) begin
            if (expected_loads.size() == 0) begin
                reportEvent("loadn_unexpected", "loadn strobe", "no strobe");
            end else begin
                want = expected_loads.pop_front();
                checkOutput("loadn_data", 32'(data), 32'(want));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int en_seen;
        int waited;

        clr       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'hF;
        door_open = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset_values");
        checkOutput("reset_state", 32'(dut.state), 32'(ST_IDLE));
        clr = 1'b0;
        nextCycle();
        checkReset("idle_after_reset");

        // Enter 1:30 and start.
        $display("[TB] entry 1,3,0 then START");
        expected_loads.push_back(4'd1); applyStimulus(4'd1);
        expected_loads.push_back(4'd3); applyStimulus(4'd3);
        expected_loads.push_back(4'd0); applyStimulus(4'd0);
        checkOutput("t1_digit_count", 32'(digit_count), 32'd3);
        checkOutput("t1_shadow", 32'({dut.shadow_min, dut.shadow_tens, dut.shadow_units}), 32'h130);
        applyStimulus(KEY_START);
        checkOutput("t1_running", 32'(running), 32'd1);
        checkOutput("t1_en_at_entry", 32'(en), 32'd0);
        countEn(3, en_seen);
        checkOutput("t1_en_before_div", 32'(en_seen), 32'd0);
        nextCycle();
        checkOutput("t1_first_en", 32'(en), 32'd1);
        nextCycle();
        checkOutput("t1_en_width", 32'(en), 32'd0);

        // Door opens with the prescaler at 2; START while open is ignored;
        // after closing, the tick comes 2 cycles after resuming.
        $display("[TB] door interlock and resume");
        nextCycle();
        door_open = 1'b1;
        nextCycle();
        checkOutput("t3_running_door", 32'(running), 32'd0);
        checkOutput("t3_state_pause", 32'(dut.state), 32'(ST_PAUSE));
        countEn(8, en_seen);
        checkOutput("t3_no_en_paused", 32'(en_seen), 32'd0);
        applyStimulus(KEY_START);
        nextCycle();
        checkOutput("t3_start_door_open", 32'({running, 1'b0} | 2'(dut.state == ST_PAUSE)), 32'd1);
        door_open = 1'b0;
        nextCycle();
        applyStimulus(KEY_START);
        checkOutput("t3_resumed", 32'(running), 32'd1);
        nextCycle();
        checkOutput("t3_en_resume_early", 32'(en), 32'd0);
        nextCycle();
        checkOutput("t3_en_held_count", 32'(en), 32'd1);

        // STOP pauses, CLEAR then clears the timer.
        applyStimulus(KEY_STOP);
        checkOutput("t3_stop_pause", 32'(dut.state), 32'(ST_PAUSE));
        applyStimulus(KEY_CLEAR);
        checkOutput("t3_clrn_strobe", 32'({timer_clrn, key_ready}), 32'd0);
        nextCycle();
        checkOutput("t3_clrn_width", 32'(timer_clrn), 32'd1);
        checkOutput("t3_idle", 32'(dut.state), 32'(ST_IDLE));
        checkOutput("t3_count_cleared", 32'(digit_count), 32'd0);

        // Invalid seconds-tens is rejected.
        $display("[TB] entry 1,7,0 then START");
        expected_loads.push_back(4'd1); applyStimulus(4'd1);
        expected_loads.push_back(4'd7); applyStimulus(4'd7);
        expected_loads.push_back(4'd0); applyStimulus(4'd0);
        applyStimulus(KEY_START);
        checkOutput("t2_error", 32'(error), 32'd1);
        checkOutput("t2_state_entry", 32'(dut.state), 32'(ST_ENTRY));
        countEn(8, en_seen);
        checkOutput("t2_no_en", 32'(en_seen + 32'(running)), 32'd0);
        checkOutput("t2_error_sticky", 32'(error), 32'd1);
        applyStimulus(KEY_CLEAR);
        checkOutput("t2_error_cleared", 32'(error), 32'd0);
        checkOutput("t2_clrn", 32'(timer_clrn), 32'd0);

        // An all-zero time is ignored by START.
        expected_loads.push_back(4'd0); applyStimulus(4'd0);
        applyStimulus(KEY_START);
        checkOutput("blank_start_state", 32'(dut.state), 32'(ST_ENTRY));
        checkOutput("blank_start_flags", 32'({running, error}), 32'd0);

        // 0:05 runs to completion.
        $display("[TB] 0:05 to completion");
        expected_loads.push_back(4'd5); applyStimulus(4'd5);
        applyStimulus(KEY_START);
        checkOutput("t4_running", 32'(running), 32'd1);
        en_seen = 0;
        waited  = 0;
        while (timer_zero !== 1'b1 && waited < 200) begin
            nextCycle();
            waited++;
            if (en === 1'b1) en_seen++;
        end
        if (timer_zero !== 1'b1) begin
            reportEvent("t4_zero_timeout", "timer never reached zero", "timer_zero");
        end
        checkOutput("t4_en_count", 32'(en_seen), 32'd5);
        checkOutput("t4_done_not_yet", 32'(done), 32'd0);
        nextCycle();
        checkOutput("t4_done", 32'({done, running}), 32'b10);
        countEn(10, en_seen);
        checkOutput("t4_no_en_after_done", 32'(en_seen), 32'd0);
        applyStimulus(4'hE);
        checkOutput("t4_done_key_clrn", 32'({timer_clrn, done}), 32'd0);
        nextCycle();
        checkOutput("t4_done_to_idle", 32'(dut.state), 32'(ST_IDLE));

        // Four nines: the oldest digit is pushed out, count saturates.
        $display("[TB] entry 9,9,9,9");
        for (int i = 0; i < 4; i++) begin
            expected_loads.push_back(4'd9);
            applyStimulus(4'd9);
        end
        checkOutput("t5_count_sat", 32'(digit_count), 32'd3);
        checkOutput("t5_shadow", 32'({dut.shadow_min, dut.shadow_tens, dut.shadow_units}), 32'h999);
        applyStimulus(KEY_CLEAR);

        // Reset in the middle of a run.
        expected_loads.push_back(4'd2); applyStimulus(4'd2);
        expected_loads.push_back(4'd0); applyStimulus(4'd0);
        applyStimulus(KEY_START);
        checkOutput("t5_running", 32'(running), 32'd1);
        nextCycle();
        nextCycle();
        #2 clr = 1'b1;
        #1 checkReset("t5_clr_mid_run");
        checkOutput("t5_clr_state", 32'(dut.state), 32'(ST_IDLE));
        @(posedge clk);
        #1 clr = 1'b0;
        nextCycle();

`ifdef TIMER_LOADER_QUICK_START_EN
        $display("[TB] quick start from IDLE");
        expected_loads.push_back(QS_DIGIT_MIN);
        expected_loads.push_back(QS_DIGIT_TENS);
        expected_loads.push_back(QS_DIGIT_UNITS);
        applyStimulus(KEY_START);
        checkOutput("qs_ready_low", 32'(key_ready), 32'd0);
        checkOutput("qs_state", 32'(dut.state), 32'(ST_QLOAD));
        nextCycle();
        nextCycle();
        checkOutput("qs_running", 32'(running), 32'd1);
        checkOutput("qs_ready_last_strobe", 32'(key_ready), 32'd0);
        checkOutput("qs_shadow", 32'({dut.shadow_min, dut.shadow_tens, dut.shadow_units}), 32'h030);
        nextCycle();
        checkOutput("qs_ready_back", 32'(key_ready), 32'd1);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("qs_first_en", 32'(en), 32'd1);
`else
        $display("[TB] START in IDLE without quick start");
        applyStimulus(KEY_START);
        nextCycle();
        nextCycle();
        checkOutput("qs_absent_state", 32'(dut.state), 32'(ST_IDLE));
        checkOutput("qs_absent_flags", 32'({running, digit_count}), 32'd0);
`endif

        // Reset while a load strobe is on the wire aborts it.
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        nextCycle();
        applyStimulus(4'd4);
        #2 clr = 1'b1;
        #1 checkOutput("abort_loadn", 32'({loadn, digit_count}), 32'b100);
        @(posedge clk);
        #1 clr = 1'b0;
        nextCycle();
        nextCycle();

        checkOutput("loads_pending", 32'(expected_loads.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_evaluated, failures);
        $finish;
    end

endmodule
